shift_ctrl: RTL and testbench
=============================

Name: shift_ctrl

Overview:
- Sequencing front end for the combinational barrel shifter in the ALU datapath. Sits directly upstream of it and also consumes its output.
- Accepts shift requests over a valid/ready handshake and decodes the opcode into shifter controls. Holds the shifter operands stable for a configurable settle window, then captures the result into a response register with its own valid/ready handshake.
- Also handles illegal opcodes and shift amounts of 32 or more, which the shifter cannot represent.

Parameters:
- SETTLE, 1: cycles shifter inputs are held before OUT is captured; legal range 1..15.
- MASK_AMOUNT, 1: 1 = shift amount taken modulo 32; 0 = amounts >= 32 saturate (see Behaviour).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- N_RST  input  1  asynchronous, active-low reset.
- REQ_VALID  input  1  request present.
- REQ_READY  output  1  request accepted at this edge if REQ_VALID.
- REQ_OP  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 illegal.
- REQ_DATA  input  32  value to shift.
- REQ_AMT  input  8  shift amount, unsigned.
- SH_IN  output  32  to shifter IN.
- SH_SHFT  output  5  to shifter SHFT.
- SH_LEFT  output  1  to shifter LEFT.
- SH_ARITH  output  1  to shifter ARITH.
- SH_OUT  input  32  from shifter OUT.
- RESP_VALID  output  1  response present.
- RESP_READY  input  1  response consumed at this edge if RESP_VALID.
- RESP_DATA  output  32  shift result.
- RESP_ERR  output  1  set for an illegal opcode.

Behaviour:
- Reset (N_RST low, asynchronous):
  - State goes to IDLE and the settle counter to 0.
  - SH_IN, SH_SHFT, SH_LEFT, SH_ARITH, RESP_VALID, RESP_DATA and RESP_ERR are all 0.
  - REQ_READY is 0 while N_RST is low.
  - A request or response in flight is discarded, with no partial response afterwards.
- States: IDLE, WAIT, DONE.
- REQ_READY is combinational: 1 in IDLE, or in DONE when RESP_READY=1. It is 0 in WAIT.
- Accept (REQ_VALID && REQ_READY at an edge):
  - SH_IN <= REQ_DATA.
  - SH_SHFT <= REQ_AMT[4:0].
  - SH_LEFT <= (OP==00).
  - SH_ARITH <= (OP==10).
  - For OP 11, SH_LEFT and SH_ARITH are both 0.
  - Internal flags latched: over = !MASK_AMOUNT && REQ_AMT[7:5]!=0; illegal = (OP==11).
  - Counter <= SETTLE-1; state goes to WAIT.
- WAIT:
  - The SH_* outputs must not change.
  - Counter decrements each cycle.
  - At the edge where the counter is 0, go to DONE, set RESP_VALID <= 1 and capture RESP_DATA/RESP_ERR:
    - illegal: RESP_DATA 0, RESP_ERR 1.
    - over and SLL/SRL: RESP_DATA 0, RESP_ERR 0.
    - over and SRA: RESP_DATA = {32{SH_IN[31]}}, RESP_ERR 0.
    - otherwise: RESP_DATA = SH_OUT, RESP_ERR 0.
- Latency: with the accept at edge 0, RESP_VALID is high after edge SETTLE. Latency is identical for all op/amount cases.
- DONE:
  - RESP_VALID, RESP_DATA and RESP_ERR are held stable while RESP_READY=0, for unlimited backpressure.
  - Handshake with no new request: RESP_VALID <= 0; state goes to IDLE. RESP_DATA keeps its last value.
  - Handshake with a simultaneous new request: the request is accepted, RESP_VALID <= 0 and state goes to WAIT. Back-to-back throughput is one result per SETTLE+1 cycles.
- Invariants:
  - SH_LEFT && SH_ARITH is never 1.
  - SH_* change only on an accept edge.
  - RESP_VALID never drops without a handshake, except on reset.
- REQ_AMT bits [7:5] are ignored when MASK_AMOUNT=1.
- Formal: assert the invariants above. Assert the RESP_DATA reference model: SLL = data<<amt; SRL = data>>amt; SRA = signed data>>>amt, with amt masked or saturated per MASK_AMOUNT.

Test Plan:
- SETTLE=1. SLL, DATA=0x0000_0001, AMT=31, RESP_READY=1 -> RESP_VALID after edge 1, RESP_DATA=0x8000_0000, RESP_ERR=0; SH_LEFT=1 and SH_ARITH=0 during WAIT.
- SETTLE=3. SRA, DATA=0x8000_00F0, AMT=4 -> RESP_VALID after edge 3, RESP_DATA=0xF800_000F. REQ_READY=0 for the 3 intervening cycles.
- MASK_AMOUNT=0. SRA, DATA=0x9000_0000, AMT=40 -> RESP_DATA=0xFFFF_FFFF. SRL with the same inputs -> 0x0000_0000. With MASK_AMOUNT=1 the same SRL (amount 8) -> 0x0090_0000.
- OP=11, DATA=0x1234_5678 -> RESP_ERR=1, RESP_DATA=0; SH_LEFT=SH_ARITH=0 throughout.
- Backpressure: RESP_READY=0 for 5 cycles -> RESP_VALID/DATA stable and REQ_READY=0. Then RESP_READY=1 with a new SRL (0xFF00_0000, AMT 8) in the same cycle -> both handshakes occur and the next result is 0x00FF_0000, SETTLE edges later.
- Assert N_RST low mid-WAIT -> all outputs 0 immediately, without a clock edge. After release, REQ_READY=1 and no stale response appears.

Source files
------------

// File: rtl/shift_ctrl.sv
// shift_ctrl: sequencing front end for the external combinational barrel shifter.
// Accepts a shift request, drives the shifter controls, holds them for SETTLE
// cycles, then captures the shifter output into a response register. Opcode 11 and
// amounts of 32 or more (when not masked) are resolved here rather than in
// the shifter.
module shift_ctrl #(
  // Cycles the shifter inputs are held before the result is captured (1..15).
  parameter int unsigned SETTLE      = 1,
  // 1: amount taken modulo 32; 0: amounts >= 32 saturate.
  parameter bit          MASK_AMOUNT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  // request channel
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req_data_i,
  input  logic [7:0]  req_amt_i,
  // shifter controls and result
  output logic [31:0] sh_in_o,
  output logic [4:0]  sh_shft_o,
  output logic        sh_left_o,
  output logic        sh_arith_o,
  input  logic [31:0] sh_out_i,
  // response channel
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic        resp_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  // Counter reload value: the result is captured SETTLE edges after the accept.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] sh_in_q, sh_in_d;
  logic [4:0]  sh_shft_q, sh_shft_d;
  logic        sh_left_q, sh_left_d;
  logic        sh_arith_q, sh_arith_d;
  logic        over_q, over_d;
  logic        illegal_q, illegal_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  logic        req_ready;
  logic        accept;
  logic [31:0] capture_data;
  logic        capture_err;

  // Golden result from the latched operands, used only by the self-checks below.
  function automatic logic [31:0] model_result(
    input logic [31:0] value,
    input logic [4:0]  amt,
    input logic        left,
    input logic        arith,
    input logic        over,
    input logic        illegal
  );
    logic [31:0] r;
    if (illegal) begin
      r = '0;
    end else if (over) begin
      r = arith ? {32{value[31]}} : '0;
    end else if (left) begin
      r = value << amt;
    end else if (arith) begin
      r = 32'($signed(value) >>> amt);
    end else begin
      r = value >> amt;
    end
    return r;
  endfunction

  // A new request can be taken when idle, or when the pending response retires this edge.
  always_comb begin
    req_ready = 1'b0;
    if (rst_n) begin
      req_ready = (state_q == ST_IDLE) ||
                  ((state_q == ST_DONE) && resp_ready_i);
    end
  end

  assign accept = req_valid_i && req_ready;

  // Result selection at capture time: illegal ops and saturated amounts bypass the shifter.
  always_comb begin
    capture_data = sh_out_i;
    capture_err  = 1'b0;
    if (illegal_q) begin
      capture_data = '0;
      capture_err  = 1'b1;
    end else if (over_q) begin
      capture_data = sh_arith_q ? {32{sh_in_q[31]}} : '0;
    end
  end

  // Next-state logic: accept loads the shifter controls, WAIT counts down, DONE holds the response.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sh_in_d      = sh_in_q;
    sh_shft_d    = sh_shft_q;
    sh_left_d    = sh_left_q;
    sh_arith_d   = sh_arith_q;
    over_d       = over_q;
    illegal_d    = illegal_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = ST_DONE;
          resp_valid_d = 1'b1;
          resp_data_d  = capture_data;
          resp_err_d   = capture_err;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Accept is only possible from IDLE or a retiring DONE, so it overrides the above.
    if (accept) begin
      sh_in_d    = req_data_i;
      sh_shft_d  = req_amt_i[4:0];
      sh_left_d  = (req_op_i == OP_SLL);
      sh_arith_d = (req_op_i == OP_SRA);
      over_d     = !MASK_AMOUNT && (req_amt_i[7:5] != 3'b000);
      illegal_d  = (req_op_i == OP_ILL);
      cnt_d      = CNT_LOAD;
      state_d    = ST_WAIT;
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sh_in_q      <= '0;
      sh_shft_q    <= '0;
      sh_left_q    <= 1'b0;
      sh_arith_q   <= 1'b0;
      over_q       <= 1'b0;
      illegal_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_in_q      <= sh_in_d;
      sh_shft_q    <= sh_shft_d;
      sh_left_q    <= sh_left_d;
      sh_arith_q   <= sh_arith_d;
      over_q       <= over_d;
      illegal_q    <= illegal_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Invariant checks evaluated on every edge outside reset (ignored by synthesis).
  always_ff @(posedge clk) begin
    if (rst_n) begin
      // Left and arithmetic are mutually exclusive shifter modes.
      assert (!(sh_left_q && sh_arith_q));
      // Shifter controls only move on an accept edge.
      if (!accept) begin
        assert (sh_in_d == sh_in_q);
        assert (sh_shft_d == sh_shft_q);
        assert (sh_left_d == sh_left_q);
        assert (sh_arith_d == sh_arith_q);
      end
      // A pending response survives backpressure unchanged.
      if (resp_valid_q && !resp_ready_i) begin
        assert (resp_valid_d);
        assert (resp_data_d == resp_data_q);
        assert (resp_err_d == resp_err_q);
      end
      // Captured result matches the arithmetic definition of the operation.
      if ((state_q == ST_WAIT) && (cnt_q == 4'd0)) begin
        assert (resp_data_d == model_result(sh_in_q, sh_shft_q, sh_left_q,
                                            sh_arith_q, over_q, illegal_q));
        assert (resp_err_d == illegal_q);
      end
    end
  end

  assign req_ready_o  = req_ready;
  assign sh_in_o      = sh_in_q;
  assign sh_shft_o    = sh_shft_q;
  assign sh_left_o    = sh_left_q;
  assign sh_arith_o   = sh_arith_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Testbench for shift_ctrl: two instances (SETTLE=1/mask, SETTLE=3/saturate),
// each with a behavioural barrel shifter, directed cases then random traffic.
module tb_shift_ctrl;

  logic        clk;
  logic        rst_n;

  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [1:0]  req_op     [2];
  logic [31:0] req_data   [2];
  logic [7:0]  req_amt    [2];
  logic [31:0] sh_in      [2];
  logic [4:0]  sh_shft    [2];
  logic        sh_left    [2];
  logic        sh_arith   [2];
  logic [31:0] sh_out     [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_data  [2];
  logic        resp_err   [2];

  int checks = 0;
  int errors = 0;
  bit pending [2];

  // Combinational barrel shifter standing in for the real datapath block.
  function automatic logic [31:0] barrel(input logic [31:0] v, input logic [4:0] s,
                                         input logic left, input logic arith);
    if (left)  return v << s;
    if (arith) return 32'($signed(v) >>> s);
    return v >> s;
  endfunction

  // Instance 0: SETTLE=1, MASK_AMOUNT=1.  Instance 1: SETTLE=3, MASK_AMOUNT=0.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    shift_ctrl #(
      .SETTLE      ((gi == 0) ? 1 : 3),
      .MASK_AMOUNT ((gi == 0) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid_i  (req_valid[gi]),
      .req_ready_o  (req_ready[gi]),
      .req_op_i     (req_op[gi]),
      .req_data_i   (req_data[gi]),
      .req_amt_i    (req_amt[gi]),
      .sh_in_o      (sh_in[gi]),
      .sh_shft_o    (sh_shft[gi]),
      .sh_left_o    (sh_left[gi]),
      .sh_arith_o   (sh_arith[gi]),
      .sh_out_i     (sh_out[gi]),
      .resp_valid_o (resp_valid[gi]),
      .resp_ready_i (resp_ready[gi]),
      .resp_data_o  (resp_data[gi]),
      .resp_err_o   (resp_err[gi])
    );
    assign sh_out[gi] = barrel(sh_in[gi], sh_shft[gi], sh_left[gi], sh_arith[gi]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int settle_of(input int sel);
    return (sel == 0) ? 1 : 3;
  endfunction

  function automatic bit mask_of(input int sel);
    return (sel == 0);
  endfunction

  // Reference: result of the operation as defined arithmetically, {err, data}.
  function automatic logic [32:0] ref_model(input logic [1:0] op, input logic [31:0] data,
                                            input logic [7:0] amt, input bit mask);
    int a;
    if (op == 2'b11) return {1'b1, 32'h0};
    a = mask ? (int'(amt) % 32) : int'(amt);
    if (a >= 32) return {1'b0, ((op == 2'b10) && data[31]) ? 32'hFFFF_FFFF : 32'h0};
    case (op)
      2'b00:   return {1'b0, data << a};
      2'b01:   return {1'b0, data >> a};
      default: return {1'b0, 32'($signed(data) >>> a)};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input int sel);
    check("rst_req_ready", 32'(req_ready[sel]), 0);
    check("rst_sh_in", sh_in[sel], 0);
    check("rst_sh_shft", 32'(sh_shft[sel]), 0);
    check("rst_sh_left", 32'(sh_left[sel]), 0);
    check("rst_sh_arith", 32'(sh_arith[sel]), 0);
    check("rst_resp_valid", 32'(resp_valid[sel]), 0);
    check("rst_resp_data", resp_data[sel], 0);
    check("rst_resp_err", 32'(resp_err[sel]), 0);
  endtask

  // Present a request at a negedge; if a response is pending, retire it on the same edge.
  task automatic send(input int sel, input logic [1:0] op, input logic [31:0] data,
                      input logic [7:0] amt);
    req_valid[sel]  = 1'b1;
    req_op[sel]     = op;
    req_data[sel]   = data;
    req_amt[sel]    = amt;
    resp_ready[sel] = pending[sel];
    #1;
    check("rdy_accept", 32'(req_ready[sel]), 1);
    @(negedge clk);
    req_valid[sel]  = 1'b0;
    resp_ready[sel] = 1'b0;
    if (pending[sel]) check("b2b_resp_drop", 32'(resp_valid[sel]), 0);
    pending[sel] = 1'b0;
  endtask

  // Called at the negedge after the accept edge: watch WAIT, measure latency, hold under backpressure.
  task automatic collect(input int sel, input logic [1:0] op, input logic [31:0] data,
                         input logic [7:0] amt, input logic [31:0] exp_d, input logic exp_e,
                         input int bp);
    int e;
    e = 0;
    while (!resp_valid[sel] && e < 40) begin
      check("rdy_wait", 32'(req_ready[sel]), 0);
      check("sh_in", sh_in[sel], data);
      check("sh_shft", 32'(sh_shft[sel]), 32'(amt[4:0]));
      check("sh_left", 32'(sh_left[sel]), 32'(op == 2'b00));
      check("sh_arith", 32'(sh_arith[sel]), 32'(op == 2'b10));
      @(negedge clk);
      e++;
    end
    check("latency", 32'(e), 32'(settle_of(sel)));
    check("resp_data", resp_data[sel], exp_d);
    check("resp_err", 32'(resp_err[sel]), 32'(exp_e));
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(resp_valid[sel]), 1);
      check("bp_data", resp_data[sel], exp_d);
      check("bp_err", 32'(resp_err[sel]), 32'(exp_e));
      check("bp_rdy", 32'(req_ready[sel]), 0);
    end
    pending[sel] = 1'b1;
  endtask

  // Retire the pending response with no new request.
  task automatic release_resp(input int sel, input logic [31:0] last_d);
    resp_ready[sel] = 1'b1;
    #1;
    check("rdy_done", 32'(req_ready[sel]), 1);
    @(negedge clk);
    resp_ready[sel] = 1'b0;
    check("rel_valid", 32'(resp_valid[sel]), 0);
    check("rel_data_kept", resp_data[sel], last_d);
    check("rel_idle_rdy", 32'(req_ready[sel]), 1);
    pending[sel] = 1'b0;
  endtask

  // One complete transaction using the reference model for expectations.
  task automatic txn(input int sel, input logic [1:0] op, input logic [31:0] data,
                     input logic [7:0] amt, input int bp, output logic [31:0] got_exp);
    logic [32:0] r;
    r = ref_model(op, data, amt, mask_of(sel));
    send(sel, op, data, amt);
    collect(sel, op, data, amt, r[31:0], r[32], bp);
    got_exp = r[31:0];
  endtask

  initial begin
    logic [31:0] last;
    logic [1:0]  op;
    logic [31:0] data;
    logic [7:0]  amt;

    for (int i = 0; i < 2; i++) begin
      req_valid[i]  = 1'b0;
      req_op[i]     = 2'b00;
      req_data[i]   = '0;
      req_amt[i]    = '0;
      resp_ready[i] = 1'b0;
      pending[i]    = 1'b0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero(0);
    check_zero(1);
    rst_n = 1'b1;
    #1;
    check("rdy_after_rst0", 32'(req_ready[0]), 1);
    check("rdy_after_rst1", 32'(req_ready[1]), 1);
    @(negedge clk);

    // SLL 1 by 31, SETTLE=1.
    send(0, 2'b00, 32'h0000_0001, 8'd31);
    collect(0, 2'b00, 32'h0000_0001, 8'd31, 32'h8000_0000, 1'b0, 0);
    release_resp(0, 32'h8000_0000);

    // SRA with SETTLE=3.
    send(1, 2'b10, 32'h8000_00F0, 8'd4);
    collect(1, 2'b10, 32'h8000_00F0, 8'd4, 32'hF800_000F, 1'b0, 0);
    release_resp(1, 32'hF800_000F);

    // Amount 40: saturate on instance 1, modulo 32 on instance 0.
    send(1, 2'b10, 32'h9000_0000, 8'd40);
    collect(1, 2'b10, 32'h9000_0000, 8'd40, 32'hFFFF_FFFF, 1'b0, 0);
    release_resp(1, 32'hFFFF_FFFF);
    send(1, 2'b01, 32'h9000_0000, 8'd40);
    collect(1, 2'b01, 32'h9000_0000, 8'd40, 32'h0000_0000, 1'b0, 0);
    release_resp(1, 32'h0000_0000);
    send(0, 2'b01, 32'h9000_0000, 8'd40);
    collect(0, 2'b01, 32'h9000_0000, 8'd40, 32'h0090_0000, 1'b0, 0);
    release_resp(0, 32'h0090_0000);

    // Illegal opcode on both instances.
    send(0, 2'b11, 32'h1234_5678, 8'd3);
    collect(0, 2'b11, 32'h1234_5678, 8'd3, 32'h0, 1'b1, 0);
    release_resp(0, 32'h0);
    send(1, 2'b11, 32'h1234_5678, 8'd3);
    collect(1, 2'b11, 32'h1234_5678, 8'd3, 32'h0, 1'b1, 0);
    release_resp(1, 32'h0);

    // Five cycles of backpressure, then retire together with a new SRL.
    send(1, 2'b00, 32'h0000_00AB, 8'd4);
    collect(1, 2'b00, 32'h0000_00AB, 8'd4, 32'h0000_0AB0, 1'b0, 5);
    send(1, 2'b01, 32'hFF00_0000, 8'd8);
    collect(1, 2'b01, 32'hFF00_0000, 8'd8, 32'h00FF_0000, 1'b0, 0);
    release_resp(1, 32'h00FF_0000);

    // Reset in the middle of WAIT: outputs clear without a clock edge, no stale response.
    send(1, 2'b10, 32'hDEAD_BEEF, 8'd5);
    #2 rst_n = 1'b0;
    #1;
    check_zero(1);
    check_zero(0);
    @(negedge clk);
    rst_n = 1'b1;
    pending[1] = 1'b0;
    #1;
    check("rdy_post_rst", 32'(req_ready[1]), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale_resp", 32'(resp_valid[1]), 0);
    end

    // Random traffic on both instances with random backpressure and back-to-back issue.
    for (int sel = 0; sel < 2; sel++) begin
      for (int i = 0; i < 60; i++) begin
        op   = 2'($urandom_range(0, 3));
        data = $urandom;
        amt  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom);
        txn(sel, op, data, amt, $urandom_range(0, 3), last);
        if ($urandom_range(0, 1) == 1) release_resp(sel, last);
      end
      if (pending[sel]) release_resp(sel, last);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
